// File: rtl/mdu_controller_if.sv
// Execute-stage <-> multiply/divide unit signal bundle.
// master: execute stage side; slave: the MDU sequencer.
interface mdu_controller_if #(
  parameter int DWIDTH      = 32,
  parameter int FUNCT_WIDTH = 6
);
  logic                   mdc_i_ce;
  logic                   mdc_i_rtype;
  logic [FUNCT_WIDTH-1:0] mdc_i_funct;
  logic [DWIDTH-1:0]      mdc_i_data_rs;
  logic [DWIDTH-1:0]      mdc_i_data_rt;
  logic                   mdc_o_stall;
  logic                   mdc_o_busy;
  logic                   mdc_o_done;
  logic [DWIDTH-1:0]      mdc_o_hilo_value;
  logic                   mdc_o_hilo_valid;
  logic [DWIDTH-1:0]      mdc_o_hi;
  logic [DWIDTH-1:0]      mdc_o_lo;

  modport master (
    output mdc_i_ce, mdc_i_rtype, mdc_i_funct, mdc_i_data_rs, mdc_i_data_rt,
    input  mdc_o_stall, mdc_o_busy, mdc_o_done, mdc_o_hilo_value,
           mdc_o_hilo_valid, mdc_o_hi, mdc_o_lo
  );

  modport slave (
    input  mdc_i_ce, mdc_i_rtype, mdc_i_funct, mdc_i_data_rs, mdc_i_data_rt,
    output mdc_o_stall, mdc_o_busy, mdc_o_done, mdc_o_hilo_value,
           mdc_o_hilo_valid, mdc_o_hi, mdc_o_lo
  );
endinterface

// File: rtl/mdu_controller.sv
// Iterative multiply/divide sequencer owning HI/LO.
// One multiplier/quotient bit per cycle on magnitudes; signs are applied
// in a final FIX cycle. A single 2*DWIDTH accumulator serves both ops:
// product for MUL, {remainder, dividend/quotient} for DIV.
module mdu_controller #(
  parameter int DWIDTH      = 32,
  parameter int FUNCT_WIDTH = 6,
  parameter int CNT_WIDTH   = 6
) (
  input logic              mdc_i_clk,
  input logic              mdc_i_rst,
  mdu_controller_if.slave  bus
);

  localparam logic [FUNCT_WIDTH-1:0] F_MFHI  = FUNCT_WIDTH'(6'h10);
  localparam logic [FUNCT_WIDTH-1:0] F_MTHI  = FUNCT_WIDTH'(6'h11);
  localparam logic [FUNCT_WIDTH-1:0] F_MFLO  = FUNCT_WIDTH'(6'h12);
  localparam logic [FUNCT_WIDTH-1:0] F_MTLO  = FUNCT_WIDTH'(6'h13);
  localparam logic [FUNCT_WIDTH-1:0] F_MULT  = FUNCT_WIDTH'(6'h18);
  localparam logic [FUNCT_WIDTH-1:0] F_MULTU = FUNCT_WIDTH'(6'h19);
  localparam logic [FUNCT_WIDTH-1:0] F_DIV   = FUNCT_WIDTH'(6'h1A);
  localparam logic [FUNCT_WIDTH-1:0] F_DIVU  = FUNCT_WIDTH'(6'h1B);
  localparam logic [CNT_WIDTH-1:0]   CNT_LAST = CNT_WIDTH'(DWIDTH - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX, ST_DONE} state_t;

  state_t                state;
  logic [DWIDTH-1:0]     hi_r;
  logic [DWIDTH-1:0]     lo_r;
  logic [DWIDTH-1:0]     opb;
  logic [2*DWIDTH-1:0]   acc;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  busy_r;
  logic                  done_r;
  logic                  op_div;
  logic                  neg_q;
  logic                  neg_r;

  // Two's-complement negate, wrapping modulo the width.
  function automatic logic [DWIDTH-1:0] neg_w(input logic [DWIDTH-1:0] v);
    return ~v + DWIDTH'(1);
  endfunction

  function automatic logic [2*DWIDTH-1:0] neg_2w(input logic [2*DWIDTH-1:0] v);
    return ~v + (2*DWIDTH)'(1);
  endfunction

  // Magnitude of a signed operand; the most negative value maps to itself,
  // which is still correct when read back as unsigned.
  function automatic logic [DWIDTH-1:0] abs_w(input logic signed [DWIDTH-1:0] v);
    return v[DWIDTH-1] ? neg_w(v) : v;
  endfunction

  logic                    dec;
  logic                    is_mul;
  logic                    is_div;
  logic                    is_sgn;
  logic                    is_mfhi;
  logic                    is_mflo;
  logic                    is_mthi;
  logic                    is_mtlo;
  logic                    stall;
  logic                    div_zero;
  logic [DWIDTH-1:0]       a_in;
  logic [DWIDTH-1:0]       b_in;
  logic [DWIDTH:0]         mul_sum;
  logic [DWIDTH:0]         div_shift;
  logic [DWIDTH:0]         div_trial;
  logic                    q_bit;
  logic [2*DWIDTH-1:0]     prod_fix;
  logic [DWIDTH-1:0]       quo_fix;
  logic [DWIDTH-1:0]       rem_fix;

  // Instruction decode, stall, and operand conditioning for a start.
  always_comb begin
    dec      = bus.mdc_i_ce && bus.mdc_i_rtype;
    is_mul   = dec && (bus.mdc_i_funct == F_MULT || bus.mdc_i_funct == F_MULTU);
    is_div   = dec && (bus.mdc_i_funct == F_DIV  || bus.mdc_i_funct == F_DIVU);
    is_sgn   = bus.mdc_i_funct == F_MULT || bus.mdc_i_funct == F_DIV;
    is_mfhi  = dec && bus.mdc_i_funct == F_MFHI;
    is_mflo  = dec && bus.mdc_i_funct == F_MFLO;
    is_mthi  = dec && bus.mdc_i_funct == F_MTHI;
    is_mtlo  = dec && bus.mdc_i_funct == F_MTLO;
    stall    = busy_r && (is_mul || is_div || is_mfhi || is_mflo || is_mthi || is_mtlo);
    div_zero = bus.mdc_i_data_rt == '0;
    a_in     = is_sgn ? abs_w(bus.mdc_i_data_rs) : bus.mdc_i_data_rs;
    b_in     = is_sgn ? abs_w(bus.mdc_i_data_rt) : bus.mdc_i_data_rt;
  end

  // One shift-add / restoring-divide step, and the final sign fix.
  always_comb begin
    mul_sum   = {1'b0, acc[2*DWIDTH-1:DWIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    div_shift = {acc[2*DWIDTH-1:DWIDTH], acc[DWIDTH-1]};
    div_trial = div_shift - {1'b0, opb};
    q_bit     = ~div_trial[DWIDTH];
    prod_fix  = neg_q ? neg_2w(acc) : acc;
    quo_fix   = neg_q ? neg_w(acc[DWIDTH-1:0]) : acc[DWIDTH-1:0];
    rem_fix   = neg_r ? neg_w(acc[2*DWIDTH-1:DWIDTH]) : acc[2*DWIDTH-1:DWIDTH];
  end

  assign bus.mdc_o_stall      = stall;
  assign bus.mdc_o_busy       = busy_r;
  assign bus.mdc_o_done       = done_r;
  assign bus.mdc_o_hi         = hi_r;
  assign bus.mdc_o_lo         = lo_r;
  assign bus.mdc_o_hilo_valid = (is_mfhi || is_mflo) && !stall;
  assign bus.mdc_o_hilo_value = stall ? '0 : is_mfhi ? hi_r : is_mflo ? lo_r : '0;

  // Sequencer FSM with HI/LO ownership and iteration datapath.
  always_ff @(posedge mdc_i_clk) begin
    if (!mdc_i_rst) begin
      state  <= ST_IDLE;
      hi_r   <= '0;
      lo_r   <= '0;
      opb    <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      op_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (is_mthi && !stall) hi_r <= bus.mdc_i_data_rs;
      if (is_mtlo && !stall) lo_r <= bus.mdc_i_data_rs;
      case (state)
        ST_IDLE, ST_DONE: begin
          state <= ST_IDLE;
          cnt   <= '0;
          if (is_mul) begin
            state  <= ST_MUL;
            busy_r <= 1'b1;
            op_div <= 1'b0;
            opb    <= a_in;
            acc    <= {{DWIDTH{1'b0}}, b_in};
            neg_q  <= is_sgn && (bus.mdc_i_data_rs[DWIDTH-1] ^ bus.mdc_i_data_rt[DWIDTH-1]);
            neg_r  <= 1'b0;
          end else if (is_div) begin
            // Divide by zero keeps the raw dividend so the remainder
            // comes out as rs untouched, with the quotient all ones.
            state  <= ST_DIV;
            busy_r <= 1'b1;
            op_div <= 1'b1;
            opb    <= b_in;
            acc    <= {{DWIDTH{1'b0}}, div_zero ? bus.mdc_i_data_rs : a_in};
            neg_q  <= is_sgn && !div_zero &&
                      (bus.mdc_i_data_rs[DWIDTH-1] ^ bus.mdc_i_data_rt[DWIDTH-1]);
            neg_r  <= is_sgn && !div_zero && bus.mdc_i_data_rs[DWIDTH-1];
          end
        end
        ST_MUL: begin
          acc <= {mul_sum, acc[DWIDTH-1:1]};
          cnt <= cnt + CNT_WIDTH'(1);
          if (cnt == CNT_LAST) state <= ST_FIX;
        end
        ST_DIV: begin
          acc <= {q_bit ? div_trial[DWIDTH-1:0] : div_shift[DWIDTH-1:0],
                  acc[DWIDTH-2:0], q_bit};
          cnt <= cnt + CNT_WIDTH'(1);
          if (cnt == CNT_LAST) state <= ST_FIX;
        end
        ST_FIX: begin
          if (op_div) begin
            hi_r <= rem_fix;
            lo_r <= quo_fix;
          end else begin
            hi_r <= prod_fix[2*DWIDTH-1:DWIDTH];
            lo_r <= prod_fix[DWIDTH-1:0];
          end
          state  <= ST_DONE;
          busy_r <= 1'b0;
          done_r <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_controller.sv
// Bench for mdu_controller: directed vectors, an arithmetic reference model
// compared every cycle, and literal expectations for the headline cases.
module tb_mdu_controller;
  localparam int W = 32;
  localparam logic [5:0] MFHI = 6'h10, MTHI = 6'h11, MFLO = 6'h12, MTLO = 6'h13;
  localparam logic [5:0] MULT = 6'h18, MULTU = 6'h19, DIV = 6'h1A, DIVU = 6'h1B;
  localparam logic [5:0] ADD = 6'h20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mdu_controller_if #(.DWIDTH(W), .FUNCT_WIDTH(6)) bus ();

  mdu_controller #(.DWIDTH(W), .FUNCT_WIDTH(6), .CNT_WIDTH(6)) dut (
    .mdc_i_clk (clk),
    .mdc_i_rst (rst),
    .bus       (bus)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference results straight from the arithmetic definition.
  function automatic void model_res(input logic [5:0] f, input logic [31:0] rs,
                                    input logic [31:0] rt,
                                    output logic [31:0] h, output logic [31:0] l);
    logic [63:0] p;
    h = '0;
    l = '0;
    case (f)
      MULT: begin
        p = 64'(longint'($signed(rs)) * longint'($signed(rt)));
        h = p[63:32];
        l = p[31:0];
      end
      MULTU: begin
        p = {32'b0, rs} * {32'b0, rt};
        h = p[63:32];
        l = p[31:0];
      end
      DIV: begin
        if (rt == 0) begin l = '1; h = rs; end
        else if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) begin
          l = 32'h8000_0000; h = '0;
        end else begin
          l = 32'($signed(rs) / $signed(rt));
          h = 32'($signed(rs) % $signed(rt));
        end
      end
      default: begin
        if (rt == 0) begin l = '1; h = rs; end
        else begin l = rs / rt; h = rs % rt; end
      end
    endcase
  endfunction

  // Model state: HI/LO, remaining busy cycles, pending result, done pulse.
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  int          m_cnt = 0;
  logic        m_done = 1'b0;
  bit          chk_en = 1'b0;

  function automatic bit is_dec();
    return bus.mdc_i_ce && bus.mdc_i_rtype;
  endfunction

  function automatic bit is_mdu_op(input logic [5:0] f);
    return (f >= 6'h10 && f <= 6'h13) || (f >= 6'h18 && f <= 6'h1B);
  endfunction

  // Model advance at each clock edge.
  always @(posedge clk) begin
    if (!rst) begin
      m_hi = '0; m_lo = '0; m_cnt = 0; m_done = 1'b0; chk_en = 1'b1;
    end else begin
      m_done = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; end
      end else if (is_dec() && bus.mdc_i_funct >= MULT && bus.mdc_i_funct <= DIVU) begin
        model_res(bus.mdc_i_funct, bus.mdc_i_data_rs, bus.mdc_i_data_rt, p_hi, p_lo);
        m_cnt = W + 1;
      end else if (is_dec() && bus.mdc_i_funct == MTHI) begin
        m_hi = bus.mdc_i_data_rs;
      end else if (is_dec() && bus.mdc_i_funct == MTLO) begin
        m_lo = bus.mdc_i_data_rs;
      end
    end
  end

  // Compare DUT against the model mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      bit e_busy, e_stall, e_valid;
      logic [31:0] e_val;
      e_busy  = m_cnt > 0;
      e_stall = e_busy && is_dec() && is_mdu_op(bus.mdc_i_funct);
      e_valid = !e_stall && is_dec() && (bus.mdc_i_funct == MFHI || bus.mdc_i_funct == MFLO);
      e_val   = !e_valid ? 32'h0 : (bus.mdc_i_funct == MFHI ? m_hi : m_lo);
      chk("busy", 32'(bus.mdc_o_busy), 32'(e_busy));
      chk("stall", 32'(bus.mdc_o_stall), 32'(e_stall));
      chk("done", 32'(bus.mdc_o_done), 32'(m_done));
      chk("hilo_valid", 32'(bus.mdc_o_hilo_valid), 32'(e_valid));
      chk("hilo_value", bus.mdc_o_hilo_value, e_val);
      chk("hi", bus.mdc_o_hi, m_hi);
      chk("lo", bus.mdc_o_lo, m_lo);
    end
  end

  task automatic drive(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
    bus.mdc_i_ce = 1'b1; bus.mdc_i_rtype = 1'b1; bus.mdc_i_funct = f;
    bus.mdc_i_data_rs = rs; bus.mdc_i_data_rt = rt;
  endtask

  task automatic idle_in();
    bus.mdc_i_ce = 1'b0; bus.mdc_i_rtype = 1'b0; bus.mdc_i_funct = '0;
    bus.mdc_i_data_rs = '0; bus.mdc_i_data_rt = '0;
  endtask

  task automatic op(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
    @(posedge clk); #1; drive(f, rs, rt);
    @(posedge clk); #1; idle_in();
  endtask

  task automatic wait_done(input string nm);
    bit seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (bus.mdc_o_done) seen = 1'b1;
    end
    chk(nm, 32'(seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n, done_at, stall_n, done_n;
    idle_in();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hi", bus.mdc_o_hi, 32'h0);
    chk("rst_lo", bus.mdc_o_lo, 32'h0);
    chk("rst_busy", 32'(bus.mdc_o_busy), 32'h0);
    @(posedge clk); #1 rst = 1'b1;

    // Signed multiply: latency and result.
    op(MULT, 32'd7, 32'hFFFF_FFFD);
    busy_n = 0; done_at = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.mdc_o_busy) busy_n++;
      if (bus.mdc_o_done && done_at == 0) done_at = k;
    end
    chk("mult_busy_cycles", 32'(busy_n), 32'd33);
    chk("mult_done_cycle", 32'(done_at), 32'd34);
    chk("mult_hi", bus.mdc_o_hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.mdc_o_lo, 32'hFFFF_FFEB);

    op(DIVU, 32'd100, 32'd7);
    wait_done("divu_done");
    chk("divu_lo", bus.mdc_o_lo, 32'd14);
    chk("divu_hi", bus.mdc_o_hi, 32'd2);

    op(DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_done");
    chk("div_lo", bus.mdc_o_lo, 32'hFFFF_FFFD);
    chk("div_hi", bus.mdc_o_hi, 32'hFFFF_FFFF);

    op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_done");
    chk("multu_hi", bus.mdc_o_hi, 32'hFFFF_FFFE);
    chk("multu_lo", bus.mdc_o_lo, 32'h0000_0001);

    // MFLO held from cycle 2 stalls until the DONE cycle.
    op(MULT, 32'd5, 32'd6);
    @(posedge clk); #1; drive(MFLO, 32'h0, 32'h0);
    stall_n = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!bus.mdc_o_stall) break;
      stall_n++;
    end
    chk("mflo_stall_cycles", 32'(stall_n), 32'd32);
    chk("mflo_done_cycle", 32'(bus.mdc_o_done), 32'd1);
    chk("mflo_valid", 32'(bus.mdc_o_hilo_valid), 32'd1);
    chk("mflo_value", bus.mdc_o_hilo_value, 32'd30);
    @(posedge clk); #1; idle_in();

    // Unrelated instruction under busy proceeds; ce low does not stall.
    op(MULT, 32'd1, 32'd1);
    @(posedge clk); #1; drive(ADD, 32'd1, 32'd2);
    @(negedge clk);
    chk("add_busy", 32'(bus.mdc_o_busy), 32'd1);
    chk("add_stall", 32'(bus.mdc_o_stall), 32'd0);
    @(posedge clk); #1; drive(MFHI, 32'd0, 32'd0); bus.mdc_i_ce = 1'b0;
    @(negedge clk);
    chk("ce_low_stall", 32'(bus.mdc_o_stall), 32'd0);
    @(posedge clk); #1; idle_in();
    wait_done("mult1_done");

    op(DIV, 32'h0000_1234, 32'h0);
    wait_done("div0_done");
    chk("div0_lo", bus.mdc_o_lo, 32'hFFFF_FFFF);
    chk("div0_hi", bus.mdc_o_hi, 32'h0000_1234);

    op(DIV, 32'h8000_0005, 32'h0);
    wait_done("div0n_done");
    chk("div0n_lo", bus.mdc_o_lo, 32'hFFFF_FFFF);
    chk("div0n_hi", bus.mdc_o_hi, 32'h8000_0005);

    op(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("ovf_done");
    chk("ovf_lo", bus.mdc_o_lo, 32'h8000_0000);
    chk("ovf_hi", bus.mdc_o_hi, 32'h0);

    // MTHI/MTLO then read back the next cycle.
    @(posedge clk); #1; drive(MTHI, 32'hA5A5_A5A5, 32'h0);
    @(posedge clk); #1; drive(MFHI, 32'h0, 32'h0);
    @(negedge clk);
    chk("mfhi_valid", 32'(bus.mdc_o_hilo_valid), 32'd1);
    chk("mfhi_value", bus.mdc_o_hilo_value, 32'hA5A5_A5A5);
    @(posedge clk); #1; drive(MTLO, 32'h1357_9BDF, 32'h0);
    @(posedge clk); #1; drive(MFLO, 32'h0, 32'h0);
    @(negedge clk);
    chk("mflo2_value", bus.mdc_o_hilo_value, 32'h1357_9BDF);

    // Start with ce low is ignored.
    @(posedge clk); #1; drive(MULT, 32'd3, 32'd3); bus.mdc_i_ce = 1'b0;
    @(posedge clk); #1; idle_in();
    @(negedge clk);
    chk("ce_low_nostart", 32'(bus.mdc_o_busy), 32'd0);

    // Reset mid-operation discards the op.
    op(MULTU, 32'd3, 32'd5);
    repeat (9) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", 32'(bus.mdc_o_busy), 32'd0);
    chk("rst_mid_stall", 32'(bus.mdc_o_stall), 32'd0);
    chk("rst_mid_hi", bus.mdc_o_hi, 32'h0);
    chk("rst_mid_lo", bus.mdc_o_lo, 32'h0);
    done_n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.mdc_o_done) done_n++;
    end
    chk("rst_mid_no_done", 32'(done_n), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_controller.md
Name: mdu_controller

Overview:
- Multi-cycle multiply/divide sequencer sitting beside the execute stage. It owns the HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU from execute and runs them iteratively, one bit per cycle.
- Serves MFHI/MFLO/MTHI/MTLO. Raises a stall to the pipeline hazard logic while a result is not yet available.

Parameters:
- DWIDTH, 32, operand/HI/LO width
- FUNCT_WIDTH, 6, funct field width
- CNT_WIDTH, 6, iteration counter width (must hold DWIDTH)

Ports:
- mdc_i_clk  input  1  clock
- mdc_i_rst  input  1  synchronous reset, active-low
- mdc_i_ce  input  1  valid instruction in execute this cycle
- mdc_i_rtype  input  1  opcode is R-type (funct meaningful)
- mdc_i_funct  input  FUNCT_WIDTH  funct field
- mdc_i_data_rs  input  DWIDTH  rs operand (multiplicand/dividend, MTHI/MTLO source)
- mdc_i_data_rt  input  DWIDTH  rt operand (multiplier/divisor)
- mdc_o_stall  output  1  hold IF/ID/EX, bubble into MEM
- mdc_o_busy  output  1  operation in flight
- mdc_o_done  output  1  one-cycle pulse when HI/LO updated by mult/div
- mdc_o_hilo_value  output  DWIDTH  HI (MFHI) or LO (MFLO) read data
- mdc_o_hilo_valid  output  1  mdc_o_hilo_value valid this cycle
- mdc_o_hi  output  DWIDTH  HI register
- mdc_o_lo  output  DWIDTH  LO register

Behaviour:
- Decode is valid only when mdc_i_ce && mdc_i_rtype.
  - MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B: start ops.
  - MFHI 0x10, MFLO 0x12: read ops.
  - MTHI 0x11, MTLO 0x13: write ops.
  - Any other funct is ignored.
- Reset (mdc_i_rst low at clock edge):
  - state=IDLE; HI=LO=0; counter=0; busy=0; done=0; internal accumulators=0.
  - This applies mid-operation too: the in-flight op is discarded.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- IDLE + start op:
  - Latch |rs|, |rt| for signed ops (raw values for unsigned ops).
  - Latch result-sign flags: quotient/product sign = rs[msb]^rt[msb]; remainder sign = rs[msb].
  - Clear the accumulator, counter=0, go to MUL or DIV.
  - The start instruction itself does not stall.
- MUL: shift-add, one multiplier bit per cycle, 2*DWIDTH-bit product. After DWIDTH cycles go to FIX.
- DIV: restoring divide, one quotient bit per cycle. After DWIDTH cycles go to FIX.
- FIX:
  - Signed ops: negate product, quotient or remainder per the latched flags (two's complement, wraps modulo width).
  - Write HI/LO. MUL: HI=product[2W-1:W], LO=product[W-1:0]. DIV: LO=quotient, HI=remainder.
  - Go to DONE.
- DONE: mdc_o_done=1 for this cycle only, busy=0, go to IDLE. A new start op is accepted in DONE (behaves as IDLE).
- Latency: accept at edge N; HI/LO visible after edge N+DWIDTH+1; done high in cycle N+DWIDTH+2.
- mdc_o_busy=1 in MUL, DIV, FIX.
- mdc_o_stall=1 (combinational) when busy and a decoded MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO is presented. It is 0 otherwise. Unrelated instructions proceed under busy.
- MFHI/MFLO when not stalled:
  - mdc_o_hilo_value = HI or LO combinationally, mdc_o_hilo_valid=1 the same cycle.
  - Otherwise value=0, valid=0.
- MTHI/MTLO when not stalled: HI or LO = rs at the clock edge. Read of the same register in the next cycle returns the new value.
- Divide by zero, any signedness: no sign fix; LO={DWIDTH{1'b1}}, HI=rs. Same latency.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- mdc_i_ce low: no decode. No start, no write, no stall.

Test Plan:
- MULT rs=7, rt=0xFFFFFFFD -> busy 33 cycles, done pulse at cycle 34; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIVU rs=100, rt=7 -> LO=14, HI=2.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MULT then MFLO presented at cycle 2 -> stall high until the DONE cycle.
  - In the DONE cycle stall=0, hilo_valid=1, value=new LO.
  - An unrelated ADD during busy -> stall=0.
- DIV rs=0x1234, rt=0 -> LO=0xFFFFFFFF, HI=0x1234.
- Overflow DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0xA5A5A5A5 then MFHI next cycle -> value 0xA5A5A5A5, valid=1.
- Start MULTU, drop mdc_i_rst low at cycle 10 -> next cycle busy=0, stall=0, HI=LO=0, no done pulse.
